reg_fifo_unit: RTL and testbench

Parametrised successor to the single-stage fabric register primitive. It buffers up to DEPTH words of DATA_WIDTH bits between two fabric nodes, using valid/ready handshakes on both sides. It keeps the `en` stall input of the plain register. It adds a synchronous flush, an occupancy count and an almost-full flag, so mapped dataflow graphs can absorb latency mismatch between ALU paths.

---
 rtl/reg_fifo_unit.sv | 71 +++++++
 tb/tb_reg_fifo_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_fifo_unit.sv
// Show-ahead valid/ready FIFO buffer for fabric nodes: en stall, synchronous flush,
// occupancy count and almost-full flag. Any DEPTH >= 1.
module reg_fifo_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int AF_LEVEL   = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wp, rp;
  logic [PW-1:0]         wp_nxt, rp_nxt;
  logic [CW-1:0]         cnt;
  logic                  push, pop;

  assign in_ready    = (cnt != CW'(DEPTH));
  assign out_valid   = (cnt != '0);
  assign out_data    = out_valid ? mem[rp] : '0;
  assign count       = cnt;
  assign almost_full = (cnt >= CW'(AF_LEVEL));

  assign push = en & in_valid & in_ready & ~clr;
  assign pop  = en & out_valid & out_ready & ~clr;

  // Wrap by compare so non-power-of-two depths never index past DEPTH-1
  always_comb begin
    wp_nxt = (wp == PW'(DEPTH - 1)) ? '0 : wp + PW'(1);
    rp_nxt = (rp == PW'(DEPTH - 1)) ? '0 : rp + PW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (en && clr) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp_nxt;
      if (pop)  rp <= rp_nxt;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_data;
  end

endmodule

// File: tb/tb_reg_fifo_unit.sv
// Directed self-checking bench for reg_fifo_unit at DEPTH 4, 1 and 5.
module tb_reg_fifo_unit;

  logic clk = 1'b0;
  logic rst, en, clr;

  logic [31:0] d4_in, d4_out;
  logic        d4_iv, d4_ir, d4_ov, d4_or, d4_af;
  logic [2:0]  d4_cnt;

  logic [31:0] d1_in, d1_out;
  logic        d1_iv, d1_ir, d1_ov, d1_or, d1_af;
  logic [0:0]  d1_cnt;

  logic [31:0] d5_in, d5_out;
  logic        d5_iv, d5_ir, d5_ov, d5_or, d5_af;
  logic [2:0]  d5_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_fifo_unit #(.DATA_WIDTH(32), .DEPTH(4), .AF_LEVEL(3)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_data(d4_in), .in_valid(d4_iv), .in_ready(d4_ir),
    .out_data(d4_out), .out_valid(d4_ov), .out_ready(d4_or),
    .count(d4_cnt), .almost_full(d4_af)
  );

  reg_fifo_unit #(.DATA_WIDTH(32), .DEPTH(1), .AF_LEVEL(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_data(d1_in), .in_valid(d1_iv), .in_ready(d1_ir),
    .out_data(d1_out), .out_valid(d1_ov), .out_ready(d1_or),
    .count(d1_cnt), .almost_full(d1_af)
  );

  reg_fifo_unit #(.DATA_WIDTH(32), .DEPTH(5), .AF_LEVEL(4)) u_d5 (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .in_data(d5_in), .in_valid(d5_iv), .in_ready(d5_ir),
    .out_data(d5_out), .out_valid(d5_ov), .out_ready(d5_or),
    .count(d5_cnt), .almost_full(d5_af)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; clr = 1'b0;
    d4_in = '0; d4_iv = 1'b0; d4_or = 1'b0;
    d1_in = '0; d1_iv = 1'b0; d1_or = 1'b0;
    d5_in = '0; d5_iv = 1'b0; d5_or = 1'b0;

    #12;
    chk("rst_count", 32'(d4_cnt), 0);
    chk("rst_out_valid", 32'(d4_ov), 0);
    chk("rst_in_ready", 32'(d4_ir), 1);
    chk("rst_out_data", d4_out, 0);
    chk("rst_af", 32'(d4_af), 0);
    step();
    rst = 1'b1;

    // Fill D4 with consumer stalled
    d4_iv = 1'b1;
    d4_in = 32'h11; step();
    chk("fill1_count", 32'(d4_cnt), 1);
    chk("fill1_out_valid", 32'(d4_ov), 1);
    chk("fill1_out_data", d4_out, 32'h11);
    chk("fill1_af", 32'(d4_af), 0);
    d4_in = 32'h22; step();
    chk("fill2_count", 32'(d4_cnt), 2);
    chk("fill2_af", 32'(d4_af), 0);
    d4_in = 32'h33; step();
    chk("fill3_count", 32'(d4_cnt), 3);
    chk("fill3_af", 32'(d4_af), 1);
    chk("fill3_in_ready", 32'(d4_ir), 1);
    d4_in = 32'h44; step();
    chk("fill4_count", 32'(d4_cnt), 4);
    chk("fill4_in_ready", 32'(d4_ir), 0);
    d4_in = 32'h55; step();
    chk("overflow_count", 32'(d4_cnt), 4);
    chk("overflow_head", d4_out, 32'h11);

    // Drain
    d4_iv = 1'b0; d4_or = 1'b1;
    chk("drain_head0", d4_out, 32'h11);
    step();
    chk("drain_head1", d4_out, 32'h22);
    chk("drain_count1", 32'(d4_cnt), 3);
    chk("drain_in_ready", 32'(d4_ir), 1);
    step();
    chk("drain_head2", d4_out, 32'h33);
    step();
    chk("drain_head3", d4_out, 32'h44);
    chk("drain_count3", 32'(d4_cnt), 1);
    step();
    chk("drain_empty_valid", 32'(d4_ov), 0);
    chk("drain_empty_data", d4_out, 0);
    chk("drain_empty_count", 32'(d4_cnt), 0);

    // Streaming through, pointers wrap repeatedly
    d4_iv = 1'b1; d4_or = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d4_in = 32'(i);
      step();
      chk("stream_data", d4_out, 32'(i));
      chk("stream_count", 32'(d4_cnt), 1);
    end
    d4_iv = 1'b0;
    step();
    chk("stream_end_count", 32'(d4_cnt), 0);

    // Full with simultaneous pop: pop accepted, push refused
    d4_or = 1'b0; d4_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d4_in = 32'hA0 + 32'(i);
      step();
    end
    chk("full_count", 32'(d4_cnt), 4);
    d4_in = 32'hBB; d4_or = 1'b1;
    chk("full_in_ready", 32'(d4_ir), 0);
    step();
    chk("fullpop_count", 32'(d4_cnt), 3);
    chk("fullpop_in_ready", 32'(d4_ir), 1);
    chk("fullpop_head", d4_out, 32'hA1);
    d4_iv = 1'b0;
    step();
    chk("pre_stall_count", 32'(d4_cnt), 2);
    chk("pre_stall_head", d4_out, 32'hA2);

    // Stall: en low holds everything
    en = 1'b0; d4_iv = 1'b1; d4_or = 1'b1; d4_in = 32'hCC;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_count", 32'(d4_cnt), 2);
      chk("stall_head", d4_out, 32'hA2);
    end

    // Flush overrides push and pop
    en = 1'b1; clr = 1'b1;
    step();
    chk("flush_count", 32'(d4_cnt), 0);
    chk("flush_out_valid", 32'(d4_ov), 0);
    chk("flush_out_data", d4_out, 0);
    clr = 1'b0; d4_iv = 1'b0; d4_or = 1'b0;

    // Asynchronous reset mid-cycle with two words held
    d4_iv = 1'b1;
    d4_in = 32'h1; step();
    d4_in = 32'h2; step();
    d4_iv = 1'b0;
    chk("prereset_count", 32'(d4_cnt), 2);
    #2 rst = 1'b0;
    #1;
    chk("midrst_count", 32'(d4_cnt), 0);
    chk("midrst_out_valid", 32'(d4_ov), 0);
    chk("midrst_in_ready", 32'(d4_ir), 1);
    chk("midrst_out_data", d4_out, 0);
    chk("midrst_af", 32'(d4_af), 0);
    step();
    rst = 1'b1;

    // DEPTH = 1: alternates full/empty
    d1_iv = 1'b1; d1_in = 32'h11;
    step();
    chk("d1_count1", 32'(d1_cnt), 1);
    chk("d1_in_ready", 32'(d1_ir), 0);
    chk("d1_af", 32'(d1_af), 1);
    chk("d1_head", d1_out, 32'h11);
    d1_in = 32'h22;
    step();
    chk("d1_drop_head", d1_out, 32'h11);
    d1_or = 1'b1;
    step();
    chk("d1_pop_count", 32'(d1_cnt), 0);
    chk("d1_pop_valid", 32'(d1_ov), 0);
    step();
    chk("d1_refill_count", 32'(d1_cnt), 1);
    chk("d1_refill_head", d1_out, 32'h22);
    d1_iv = 1'b0;
    step();
    chk("d1_empty", 32'(d1_ov), 0);
    d1_or = 1'b0;

    // DEPTH = 5: fill, partial drain, refill across the 4->0 wrap, drain
    d5_iv = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d5_in = 32'h51 + 32'(i);
      step();
      chk("d5_fill_count", 32'(d5_cnt), 32'(i + 1));
      chk("d5_fill_af", 32'(d5_af), (i + 1 >= 4) ? 32'd1 : 32'd0);
      chk("d5_fill_in_ready", 32'(d5_ir), (i + 1 == 5) ? 32'd0 : 32'd1);
    end
    d5_iv = 1'b0; d5_or = 1'b1;
    step();
    chk("d5_drain_head", d5_out, 32'h52);
    step();
    chk("d5_drain_head", d5_out, 32'h53);
    chk("d5_drain_count", 32'(d5_cnt), 3);
    d5_or = 1'b0; d5_iv = 1'b1;
    d5_in = 32'h56; step();
    d5_in = 32'h57; step();
    chk("d5_refill_count", 32'(d5_cnt), 5);
    d5_iv = 1'b0; d5_or = 1'b1;
    chk("d5_wrap_head", d5_out, 32'h53);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("d5_wrap_head", d5_out, 32'h54 + 32'(i));
    end
    step();
    chk("d5_final_valid", 32'(d5_ov), 0);
    chk("d5_final_count", 32'(d5_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
